// File: rtl/wb_rom_fetch_pkg.sv
// Shared Wishbone definitions for the ROM fetch engine.
// Holds the cycle-type and burst-type codes and the fetch FSM state encoding.
package wb_rom_fetch_pkg;

   localparam logic [2:0] cti_classic   = 3'b000;
   localparam logic [2:0] cti_inc_burst = 3'b010;
   localparam logic [2:0] cti_end       = 3'b111;
   localparam logic [1:0] bte_linear    = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SPACE,
      ST_BURST,
      ST_DONE,
      ST_ERR
   } fetch_state_e;

   function automatic logic [15:0] min_beats(input logic [15:0] remaining,
                                             input logic [15:0] max_beats);
      return (remaining < max_beats) ? remaining : max_beats;
   endfunction

endpackage

// File: rtl/wb_rom_fetch_fifo.sv
// First-word-fall-through buffer between the Wishbone fetch side and the stream.
// Push and pop may coincide in any fill state; a pop on an empty buffer is ignored.
module wb_fetch_fifo #(
   parameter int dw    = 32,
   parameter int depth = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic [dw-1:0]                push_dat_i,
   input  logic                         pop_i,
   output logic [dw-1:0]                pop_dat_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(depth+1)-1:0]   free_o
);

   localparam int ptr_w = $clog2(depth);
   localparam int cnt_w = $clog2(depth + 1);

   logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
   logic [cnt_w-1:0] count_q, count_d;
   logic [dw-1:0]    mem_q [depth];
   logic [dw-1:0]    mem_d [depth];
   logic             do_push;
   logic             do_pop;

   // A push into a full buffer is accepted only when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop_i & (count_q != '0);
      do_push  = push_i & ((count_q != cnt_w'(depth)) | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat_i;
         wr_ptr_d        = wr_ptr_q + ptr_w'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + ptr_w'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + cnt_w'(1);
         2'b01:   count_d = count_q - cnt_w'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign pop_dat_o = mem_q[rd_ptr_q];
   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == cnt_w'(depth));
   assign free_o    = cnt_w'(depth) - count_q;

endmodule

// File: rtl/wb_rom_fetch.sv
// Wishbone burst reader that streams a word range out of a ROM into a ready/valid stream.
// Bursts are only launched when the buffer can absorb every beat, so the bus never stalls.
module wb_rom_fetch
   import wb_rom_fetch_pkg::*;
#(
   parameter int dw         = 32,
   parameter int aw         = 32,
   parameter int burst_len  = 4,
   parameter int fifo_depth = 8
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          start_i,
   input  logic [aw-1:0] base_adr_i,
   input  logic [15:0]   word_cnt_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic [aw-1:0] wbm_adr_o,
   output logic [3:0]    wbm_sel_o,
   output logic          wbm_we_o,
   output logic [2:0]    wbm_cti_o,
   output logic [1:0]    wbm_bte_o,
   output logic          wbm_cyc_o,
   output logic          wbm_stb_o,
   input  logic [dw-1:0] wbm_dat_i,
   input  logic          wbm_ack_i,
   input  logic          wbm_err_i,
   output logic [dw-1:0] dat_o,
   output logic          valid_o,
   input  logic          ready_i
);

   localparam int free_w = $clog2(fifo_depth + 1);
   localparam int beat_w = $clog2(burst_len + 1);

   fetch_state_e      state_q, state_d;
   logic [aw-1:0]     adr_q, adr_d;
   logic [15:0]       remaining_q, remaining_d;
   logic [beat_w-1:0] beats_q, beats_d;
   logic              single_q, single_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [free_w-1:0] fifo_free;
   logic [15:0]       next_beats;

   assign next_beats = min_beats(remaining_q, 16'(burst_len));

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q     <= ST_IDLE;
         adr_q       <= '0;
         remaining_q <= '0;
         beats_q     <= '0;
         single_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         adr_q       <= adr_d;
         remaining_q <= remaining_d;
         beats_q     <= beats_d;
         single_q    <= single_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      adr_d       = adr_q;
      remaining_d = remaining_q;
      beats_d     = beats_q;
      single_d    = single_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               adr_d       = base_adr_i & ~aw'(3);
               remaining_d = word_cnt_i;
               state_d     = (word_cnt_i == 16'd0) ? ST_DONE : ST_WAIT_SPACE;
            end
         end
         ST_WAIT_SPACE: begin
            if (!fifo_full && (16'(fifo_free) >= next_beats)) begin
               beats_d  = beat_w'(next_beats);
               single_d = (next_beats == 16'd1);
               state_d  = ST_BURST;
            end
         end
         ST_BURST: begin
            // An error terminates the transfer; that beat carries no data.
            if (wbm_err_i) begin
               state_d = ST_ERR;
            end else if (wbm_ack_i) begin
               adr_d       = adr_q + aw'(4);
               remaining_d = remaining_q - 16'd1;
               beats_d     = beats_q - beat_w'(1);
               if (beats_q == beat_w'(1)) begin
                  state_d = (remaining_q == 16'd1) ? ST_DONE : ST_WAIT_SPACE;
               end
            end
         end
         ST_DONE: begin
            if (fifo_empty) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      busy_o    = (state_q != ST_IDLE);
      done_o    = (state_q == ST_DONE) && fifo_empty;
      err_o     = (state_q == ST_ERR);
      wbm_cyc_o = (state_q == ST_BURST);
      wbm_stb_o = (state_q == ST_BURST);
      wbm_adr_o = adr_q;
      wbm_we_o  = 1'b0;
      wbm_sel_o = 4'hF;
      wbm_bte_o = bte_linear;
      wbm_cti_o = cti_classic;
      if (state_q == ST_BURST && !single_q) begin
         wbm_cti_o = (beats_q == beat_w'(1)) ? cti_end : cti_inc_burst;
      end
      fifo_push = (state_q == ST_BURST) && wbm_ack_i && !wbm_err_i;
      valid_o   = !fifo_empty;
      fifo_pop  = !fifo_empty && ready_i;
   end

   wb_fetch_fifo #(
      .dw    (dw),
      .depth (fifo_depth)
   ) u_fifo (
      .clk        (wb_clk_i),
      .rst_n      (wb_rst_i),
      .push_i     (fifo_push),
      .push_dat_i (wbm_dat_i),
      .pop_i      (fifo_pop),
      .pop_dat_o  (dat_o),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .free_o     (fifo_free)
   );

endmodule

// File: tb/tb_wb_rom_fetch.sv
// Directed bench for wb_rom_fetch: a Wishbone ROM responder returns address ^ key,
// and a negedge monitor records bus beats, stream words and status pulses.
module tb_wb_rom_fetch;

   localparam logic [31:0] data_key = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] base;
   logic [15:0] cnt;
   logic        busy, done, err;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic        we;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        cyc, stb;
   logic [31:0] wdat;
   logic        ack, werr;
   logic [31:0] sdat;
   logic        svalid;
   logic        ready;

   logic        err_arm;
   int          err_at;
   int          ack_total = 0;

   int          checks   = 0;
   int          failures = 0;

   int          clr_epoch = 0;
   int          mon_epoch = 0;
   int          cyc_now   = 0;
   logic [31:0] bus_adr[$];
   logic [2:0]  bus_cti[$];
   logic [31:0] stream[$];
   int          done_cnt = 0;
   int          err_cnt  = 0;
   int          first_ack_cyc = -1;
   int          first_pop_cyc = -1;

   always #5 clk = ~clk;

   wb_rom_fetch dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst_n),
      .start_i    (start),
      .base_adr_i (base),
      .word_cnt_i (cnt),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .wbm_adr_o  (adr),
      .wbm_sel_o  (sel),
      .wbm_we_o   (we),
      .wbm_cti_o  (cti),
      .wbm_bte_o  (bte),
      .wbm_cyc_o  (cyc),
      .wbm_stb_o  (stb),
      .wbm_dat_i  (wdat),
      .wbm_ack_i  (ack),
      .wbm_err_i  (werr),
      .dat_o      (sdat),
      .valid_o    (svalid),
      .ready_i    (ready)
   );

   // ROM slave: zero-wait acks, optional error on a chosen absolute beat
   assign werr = cyc & stb & err_arm & (ack_total == err_at);
   assign ack  = cyc & stb & ~werr;
   assign wdat = adr ^ data_key;

   always @(posedge clk) begin
      if (cyc & stb & ack) ack_total <= ack_total + 1;
   end

   always @(negedge clk) begin
      cyc_now++;
      if (mon_epoch != clr_epoch) begin
         mon_epoch = clr_epoch;
         bus_adr.delete();
         bus_cti.delete();
         stream.delete();
         done_cnt = 0;
         err_cnt  = 0;
         first_ack_cyc = -1;
         first_pop_cyc = -1;
      end
      if (cyc & stb & ack) begin
         bus_adr.push_back(adr);
         bus_cti.push_back(cti);
         if (first_ack_cyc < 0) first_ack_cyc = cyc_now;
      end
      if (svalid & ready) begin
         stream.push_back(sdat);
         if (first_pop_cyc < 0) first_pop_cyc = cyc_now;
      end
      if (done) done_cnt++;
      if (err)  err_cnt++;
   end

   function automatic logic [2:0] exp_cti(input int idx, input int total);
      int bs, len, pos;
      bs  = (idx / 4) * 4;
      len = (total - bs < 4) ? (total - bs) : 4;
      pos = idx - bs;
      if (len == 1) return 3'b000;
      return (pos == len - 1) ? 3'b111 : 3'b010;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clearMonitor();
      clr_epoch++;
      @(negedge clk);
      tick(1);
   endtask

   task automatic applyStimulus(input logic [31:0] b, input logic [15:0] c);
      base  = b;
      cnt   = c;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int max_cycles);
      int n = 0;
      while ((busy || svalid) && n < max_cycles) begin
         tick(1);
         n++;
      end
      checkOutput({tag, "_finished"}, {31'd0, !(busy || svalid)}, 32'd1);
   endtask

   task automatic checkTransfer(input string tag, input logic [31:0] b, input int n);
      logic [31:0] a;
      checkOutput({tag, "_beats"}, bus_adr.size(), n);
      checkOutput({tag, "_words"}, stream.size(), n);
      for (int i = 0; i < n; i++) begin
         a = b + 32'(4 * i);
         checkOutput($sformatf("%s_adr%0d", tag, i), bus_adr[i], a);
         checkOutput($sformatf("%s_cti%0d", tag, i), {29'd0, bus_cti[i]}, {29'd0, exp_cti(i, n)});
         checkOutput($sformatf("%s_dat%0d", tag, i), stream[i], a ^ data_key);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [2:0]  cti_s1 [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
      logic [2:0]  cti_s2 [6] = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b010, 3'b111};
      logic [31:0] adr_wrap [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      int          n;
      int          beats_at_reset;

      rst_n   = 1'b0;
      start   = 1'b0;
      ready   = 1'b1;
      base    = '0;
      cnt     = '0;
      err_arm = 1'b0;
      err_at  = -1;
      tick(3);

      $display("[TB] reset values");
      checkOutput("rst_cyc",   {31'd0, cyc},    0);
      checkOutput("rst_stb",   {31'd0, stb},    0);
      checkOutput("rst_cti",   {29'd0, cti},    0);
      checkOutput("rst_adr",   adr,             0);
      checkOutput("rst_valid", {31'd0, svalid}, 0);
      checkOutput("rst_busy",  {31'd0, busy},   0);
      checkOutput("rst_done",  {31'd0, done},   0);
      checkOutput("rst_err",   {31'd0, err},    0);
      checkOutput("fixed_sel", {28'd0, sel},    32'hF);
      checkOutput("fixed_we",  {31'd0, we},     0);
      checkOutput("fixed_bte", {30'd0, bte},    0);
      rst_n = 1'b1;
      tick(1);

      $display("[TB] single 4-beat burst, low address bits ignored");
      clearMonitor();
      applyStimulus(32'h0000_0103, 16'd4);
      checkOutput("s1_busy", {31'd0, busy}, 1);
      waitIdle("s1", 60);
      checkTransfer("s1", 32'h0000_0100, 4);
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("s1_hcti%0d", i), {29'd0, bus_cti[i]}, {29'd0, cti_s1[i]});
      checkOutput("s1_done_pulses", done_cnt, 1);
      checkOutput("s1_err_pulses", err_cnt, 0);
      checkOutput("s1_stream_latency", first_pop_cyc - first_ack_cyc, 1);

      $display("[TB] 6 words split 4+2");
      clearMonitor();
      applyStimulus(32'h0000_0200, 16'd6);
      waitIdle("s2", 80);
      checkTransfer("s2", 32'h0000_0200, 6);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("s2_hcti%0d", i), {29'd0, bus_cti[i]}, {29'd0, cti_s2[i]});
      checkOutput("s2_adr4", bus_adr[4], 32'h0000_0210);
      checkOutput("s2_done_pulses", done_cnt, 1);

      $display("[TB] 1 word classic cycle, then 0 words");
      clearMonitor();
      applyStimulus(32'h0000_0300, 16'd1);
      waitIdle("s3a", 40);
      checkTransfer("s3a", 32'h0000_0300, 1);
      checkOutput("s3a_cti_classic", {29'd0, bus_cti[0]}, 0);
      checkOutput("s3a_done_pulses", done_cnt, 1);
      clearMonitor();
      applyStimulus(32'h0000_0400, 16'd0);
      checkOutput("s3b_done_next", {31'd0, done}, 1);
      checkOutput("s3b_cyc", {31'd0, cyc}, 0);
      tick(1);
      checkOutput("s3b_done_drop", {31'd0, done}, 0);
      checkOutput("s3b_busy", {31'd0, busy}, 0);
      tick(3);
      checkOutput("s3b_no_beats", bus_adr.size(), 0);
      checkOutput("s3b_done_pulses", done_cnt, 1);

      $display("[TB] stalled consumer, 16 words into an 8-deep buffer");
      ready = 1'b0;
      clearMonitor();
      applyStimulus(32'h0000_1000, 16'd16);
      tick(40);
      checkOutput("s4_fill_beats", bus_adr.size(), 8);
      checkOutput("s4_fill_cyc", {31'd0, cyc}, 0);
      checkOutput("s4_fill_busy", {31'd0, busy}, 1);
      checkOutput("s4_fill_valid", {31'd0, svalid}, 1);
      checkOutput("s4_head_dat", sdat, 32'h5A5A_1000);
      tick(5);
      checkOutput("s4_head_stable", sdat, 32'h5A5A_1000);
      ready = 1'b1;
      tick(3);
      ready = 1'b0;
      tick(10);
      checkOutput("s4_pop3_beats", bus_adr.size(), 8);
      checkOutput("s4_pop3_cyc", {31'd0, cyc}, 0);
      checkOutput("s4_pop3_words", stream.size(), 3);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      tick(20);
      checkOutput("s4_pop4_beats", bus_adr.size(), 12);
      checkOutput("s4_done_early", done_cnt, 0);
      ready = 1'b1;
      waitIdle("s4", 300);
      checkTransfer("s4", 32'h0000_1000, 16);
      checkOutput("s4_done_pulses", done_cnt, 1);

      $display("[TB] bus error on beat 3 of 4");
      clearMonitor();
      err_arm = 1'b1;
      err_at  = ack_total + 2;
      applyStimulus(32'h0000_0500, 16'd4);
      waitIdle("s5", 60);
      err_arm = 1'b0;
      checkOutput("s5_beats", bus_adr.size(), 2);
      checkOutput("s5_words", stream.size(), 2);
      checkOutput("s5_dat0", stream[0], 32'h5A5A_0500);
      checkOutput("s5_dat1", stream[1], 32'h5A5A_0504);
      checkOutput("s5_err_pulses", err_cnt, 1);
      checkOutput("s5_done_pulses", done_cnt, 0);
      checkOutput("s5_cyc", {31'd0, cyc}, 0);

      $display("[TB] address wrap at top of space");
      clearMonitor();
      applyStimulus(32'hFFFF_FFF8, 16'd4);
      waitIdle("s6", 60);
      checkTransfer("s6", 32'hFFFF_FFF8, 4);
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("s6_hadr%0d", i), bus_adr[i], adr_wrap[i]);
      checkOutput("s6_done_pulses", done_cnt, 1);

      $display("[TB] reset in mid-burst");
      ready = 1'b0;
      clearMonitor();
      applyStimulus(32'h0000_0600, 16'd8);
      n = 0;
      while (!cyc && n < 20) begin
         tick(1);
         n++;
      end
      checkOutput("s7_cyc_seen", {31'd0, cyc}, 1);
      tick(1);
      rst_n = 1'b0;
      tick(1);
      checkOutput("s7_cyc_dropped", {31'd0, cyc}, 0);
      checkOutput("s7_fifo_empty", {31'd0, svalid}, 0);
      checkOutput("s7_busy", {31'd0, busy}, 0);
      checkOutput("s7_adr", adr, 0);
      rst_n = 1'b1;
      beats_at_reset = bus_adr.size();
      tick(5);
      checkOutput("s7_no_more_beats", bus_adr.size(), beats_at_reset);
      checkOutput("s7_still_empty", {31'd0, svalid}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_rom_fetch.md
WB_ROM_FETCH -- requirements
Module: wb_rom_fetch

Interface
REQ-001 SHALL have parameter dw, default 32: Wishbone and stream data width.
REQ-002 SHALL have parameter aw, default 32: byte address width.
REQ-003 SHALL have parameter burst_len, default 4: maximum beats per burst, power of two, range 2..16.
REQ-004 SHALL have parameter fifo_depth, default 8: output buffer depth in words, power of two, at least burst_len.
REQ-005 SHALL have port wb_clk_i, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-006 SHALL have port wb_rst_i, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port start_i, input, 1 bit: a one-cycle pulse that launches a fetch.
REQ-008 SHALL have port base_adr_i, input, aw bits: start byte address. Bits [1:0] are ignored.
REQ-009 SHALL have port word_cnt_i, input, 16 bits: number of words to fetch.
REQ-010 SHALL have ports busy_o, done_o and err_o, output, 1 bit each: fetch status.
REQ-011 SHALL have ports wbm_adr_o (aw bits), wbm_sel_o (4), wbm_we_o (1), wbm_cti_o (3), wbm_bte_o (2), wbm_cyc_o (1) and wbm_stb_o (1), all outputs: Wishbone master request.
REQ-012 SHALL have ports wbm_dat_i (dw bits), wbm_ack_i (1) and wbm_err_i (1), all inputs: Wishbone master response.
REQ-013 SHALL have stream outputs dat_o (dw bits) and valid_o (1 bit), and stream input ready_i (1 bit): the downstream consumer interface.

Function
REQ-014 SHALL drive fixed values wbm_we_o=0, wbm_sel_o=4'hF and wbm_bte_o=2'b00 (linear bursts).
REQ-015 SHALL use an FSM with states IDLE, WAIT_SPACE, BURST, DONE and ERR.
REQ-016 SHALL, in IDLE, accept start_i: latch the address with bits [1:0] forced to 0, latch the remaining count, and go to WAIT_SPACE.
REQ-017 SHALL, when start_i arrives with word_cnt_i=0, pulse done_o on the next cycle and issue no bus cycle.
REQ-018 SHALL ignore start_i in every state other than IDLE.
REQ-019 SHALL set the beat count of each burst to min(burst_len, remaining).
REQ-020 SHALL leave WAIT_SPACE for BURST only when free FIFO entries ≥ beat count, so a burst never stalls on a full buffer.
REQ-021 SHALL, in BURST, hold wbm_cyc_o and wbm_stb_o high until the final ack. There is no idle between beats.
REQ-022 SHALL drive wbm_cti_o: 3'b010 on non-final beats, 3'b111 on the final beat, and 3'b000 for a 1-beat transfer.
REQ-023 SHALL, on each wbm_ack_i, push wbm_dat_i into the FIFO, add 4 to wbm_adr_o (modulo 2^aw), and decrement remaining and the beat counter.
REQ-024 SHALL deassert cyc/stb in the cycle after the final ack, then go to DONE if remaining=0, otherwise to WAIT_SPACE.
REQ-025 SHALL produce the first stream word on the cycle after its ack, if the FIFO is empty and ready_i=1.
REQ-026 SHALL, in DONE, pulse done_o for 1 cycle once the FIFO has drained to empty, then return to IDLE.
REQ-027 SHALL, on wbm_err_i during BURST: drop cyc/stb next cycle, push no data for that beat, pulse err_o for 1 cycle, go ERR, then IDLE. Words already buffered still drain.
REQ-028 SHALL hold busy_o=1 in every state other than IDLE.
REQ-029 SHALL transfer a stream word when valid_o and ready_i are both 1. dat_o stays stable while valid_o=1 and ready_i=0.
REQ-030 SHALL allow a FIFO push and a pop in the same cycle, even when the FIFO is full or empty, without losing the word count.
REQ-031 SHALL have FIFO occupancy that never exceeds fifo_depth. Overflow is structurally impossible by REQ-020.

Reset
REQ-032 SHALL, while wb_rst_i=0 at a clock edge, put the FSM in IDLE, empty the FIFO and clear the counters.
REQ-033 SHALL hold these output values during reset: wbm_cyc_o=0, wbm_stb_o=0, wbm_cti_o=000, wbm_adr_o=0, valid_o=0, busy_o=0, done_o=0, err_o=0.
REQ-034 SHALL, on reset in mid-burst, drop wbm_cyc_o on the next edge with no further pushes. The slave sees the cycle abandoned.

Structure
REQ-035 SHALL take the CTI constants (000, 010, 111), the BTE constant (00) and the FSM state encodings from the shared Wishbone common package.
REQ-036 SHALL place the buffer in one sub-module, wb_fetch_fifo: parameters dw and depth; synchronous push/pop; outputs full, empty and a free-entry count.

Verification
REQ-037 SHALL cover this scenario: base=0x100, cnt=4, ready_i=1 → one burst, adr 0x100/104/108/10C, cti 010,010,010,111, four words in order, then a done_o pulse.
REQ-038 SHALL cover this scenario: cnt=6 with burst_len=4 → a 4-beat burst then a 2-beat burst (cti 010,111), adr continuing at base+0x10.
REQ-039 SHALL cover this scenario: cnt=1 → a single classic cycle with cti=000; cnt=0 → done_o the next cycle, and wbm_cyc_o stays 0.
REQ-040 SHALL cover this scenario: ready_i=0, cnt=16, fifo_depth=8 → exactly 8 words fetched; bus idle in WAIT_SPACE until the consumer pops 4.
REQ-041 SHALL cover this scenario: wbm_err_i on beat 3 of 4 → 2 words delivered, one err_o pulse, no done_o, back to IDLE.
REQ-042 SHALL cover this scenario: base=0xFFFF_FFF8, cnt=4 → adr 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4; plus reset mid-burst → wbm_cyc_o=0 the next cycle and the FIFO empty.
